// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//
// Decodes one RV32I integer instruction per cycle into an ALU command and
// buffers it in a two-entry queue (main register plus skid register), so
// in_ready can be a registered signal with no combinational path from
// out_ready.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   flush                           synchronous discard of buffered entries
//   in_valid / in_ready             upstream handshake
//   instr, pc, rs1_data, rs2_data   instruction, its PC and register operands
//   out_valid / out_ready           downstream ALU handshake
//   aluop, opr_a, opr_b             ALU operation and operands
//   rd, rd_we                       destination register and write enable
//   illegal                         decode fault flag
//   perf_issued, perf_stall         performance counters
//
// Configuration
//   ALU_ISSUE_PERF_EN  when defined, perf_issued counts pops and perf_stall
//                      counts cycles with out_valid && !out_ready. When
//                      undefined, both outputs are tied to zero.
// ---------------------------------------------------------------------------
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  aluop,
    output logic [31:0] opr_a,
    output logic [31:0] opr_b,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic        illegal,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_SLL   = 4'b0010;
    localparam logic [3:0] OP_SLT   = 4'b0011;
    localparam logic [3:0] OP_SLTU  = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_OR    = 4'b1000;
    localparam logic [3:0] OP_AND   = 4'b1001;
    localparam logic [3:0] OP_PASSB = 4'b1010;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef struct packed {
        logic [3:0]  aluop;
        logic [31:0] opr_a;
        logic [31:0] opr_b;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};

    entry_t dec;
    logic   dec_legal;
    logic   dec_writes;
    logic [3:0]  dec_op;
    logic [31:0] dec_a;
    logic [31:0] dec_b;

    // Decode on the input side so the buffer only stores finished commands.
    // An illegal encoding still produces an entry, but with zeroed operands.
    always_comb begin
        dec_op     = OP_ADD;
        dec_a      = 32'b0;
        dec_b      = 32'b0;
        dec_legal  = 1'b0;
        dec_writes = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a      = rs1_data;
                dec_b      = rs2_data;
                dec_writes = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_op = OP_ADD;
                        3'b001:  dec_op = OP_SLL;
                        3'b010:  dec_op = OP_SLT;
                        3'b011:  dec_op = OP_SLTU;
                        3'b100:  dec_op = OP_XOR;
                        3'b101:  dec_op = OP_SRL;
                        3'b110:  dec_op = OP_OR;
                        default: dec_op = OP_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_SRA;
                end
                // Register shifts only use the low five bits of rs2.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_b = {27'b0, rs2_data[4:0]};
                end
            end
            OPC_OPIMM: begin
                dec_a      = rs1_data;
                dec_b      = imm_i;
                dec_writes = 1'b1;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_op = OP_ADD;  end
                    3'b010: begin dec_legal = 1'b1; dec_op = OP_SLT;  end
                    3'b011: begin dec_legal = 1'b1; dec_op = OP_SLTU; end
                    3'b100: begin dec_legal = 1'b1; dec_op = OP_XOR;  end
                    3'b110: begin dec_legal = 1'b1; dec_op = OP_OR;   end
                    3'b111: begin dec_legal = 1'b1; dec_op = OP_AND;  end
                    3'b001: begin
                        dec_b     = {27'b0, instr[24:20]};
                        dec_legal = (funct7 == 7'b0000000);
                        dec_op    = OP_SLL;
                    end
                    default: begin
                        dec_b = {27'b0, instr[24:20]};
                        if (funct7 == 7'b0000000) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_SRL;
                        end else if (funct7 == 7'b0100000) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_SRA;
                        end
                    end
                endcase
            end
            OPC_LUI: begin
                dec_legal  = 1'b1;
                dec_writes = 1'b1;
                dec_op     = OP_PASSB;
                dec_b      = imm_u;
            end
            OPC_AUIPC: begin
                dec_legal  = 1'b1;
                dec_writes = 1'b1;
                dec_a      = pc;
                dec_b      = imm_u;
            end
            OPC_LOAD: begin
                dec_legal  = 1'b1;
                dec_writes = 1'b1;
                dec_a      = rs1_data;
                dec_b      = imm_i;
            end
            OPC_STORE: begin
                dec_legal = 1'b1;
                dec_a     = rs1_data;
                dec_b     = imm_s;
            end
            default: dec_legal = 1'b0;
        endcase

        dec.illegal = ~dec_legal;
        dec.rd      = instr[11:7];
        dec.rd_we   = dec_legal & dec_writes & (instr[11:7] != 5'd0);
        if (dec_legal) begin
            dec.aluop = dec_op;
            dec.opr_a = dec_a;
            dec.opr_b = dec_b;
        end else begin
            dec.aluop = OP_ADD;
            dec.opr_a = 32'b0;
            dec.opr_b = 32'b0;
        end
    end

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept;
    logic   pop;

    assign accept = in_valid & in_ready_q & ~flush;
    assign pop    = out_valid & out_ready;

    // State register and buffered payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next state and payload movement. FULL never accepts because in_ready
    // is already low there; the skid entry moves to main on a pop.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = dec;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    main_d = dec;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = dec;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        // in_ready is registered from the next state, which keeps out_ready
        // off any combinational path to in_ready.
        in_ready_d = (state_d != FULL);
    end

    // Outputs decoded from the registered state and main entry.
    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = in_ready_q;
        aluop     = main_q.aluop;
        opr_a     = main_q.opr_a;
        opr_b     = main_q.opr_b;
        rd        = main_q.rd;
        rd_we     = main_q.rd_we;
        illegal   = main_q.illegal;
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Free-running counters; they wrap naturally and ignore flush.
    always_comb begin
        perf_issued_d = perf_issued_q + {31'b0, pop};
        perf_stall_d  = perf_stall_q + {31'b0, out_valid & ~out_ready};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= 32'b0;
            perf_stall_q  <= 32'b0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`else
    assign perf_issued = 32'b0;
    assign perf_stall  = 32'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
//
// Directed testbench for alu_issue. Inputs are driven 1 time unit after a
// rising edge and outputs are sampled 1 time unit after the next rising
// edge, so every check sees the registered result of the preceding cycle.
// ---------------------------------------------------------------------------
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  aluop;
    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;

    int checkCount;
    int passCount;

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .pc          (pc),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .aluop       (aluop),
        .opr_a       (opr_a),
        .opr_b       (opr_b),
        .rd          (rd),
        .rd_we       (rd_we),
        .illegal     (illegal),
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic [31:0] ins,
                                 input logic [31:0] pcv, input logic [31:0] a,
                                 input logic [31:0] b, input logic ordy);
        in_valid  = v;
        instr     = ins;
        pc        = pcv;
        rs1_data  = a;
        rs2_data  = b;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, observed, expected);
    endtask

    // addi rd, x0, imm -- gives each queued entry a recognisable rd/opr_b.
    function automatic logic [31:0] addiInstr(input logic [4:0] r, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, r, 7'b0010011};
    endfunction

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // ---- reset state ----
        #12;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_in_ready",  {31'b0, in_ready},  32'd1);
        checkOutput("rst_aluop",     {28'b0, aluop},     32'd0);
        checkOutput("rst_opr_a",     opr_a,              32'd0);
        checkOutput("rst_opr_b",     opr_b,              32'd0);
        checkOutput("rst_rd",        {27'b0, rd},        32'd0);
        checkOutput("rst_rd_we",     {31'b0, rd_we},     32'd0);
        checkOutput("rst_illegal",   {31'b0, illegal},   32'd0);
        checkOutput("rst_perf_iss",  perf_issued,        32'd0);
        checkOutput("rst_perf_stl",  perf_stall,         32'd0);
        tick();
        rst_n = 1'b1;

        // ---- decode stream with out_ready=1 (ONE + accept + pop) ----
        // add x2, x1, x2
        applyStimulus(1'b1, 32'h00208133, 32'h0, 32'd5, 32'd7, 1'b1);
        tick();
        checkOutput("add_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("add_aluop", {28'b0, aluop},     32'h0);
        checkOutput("add_a",     opr_a,              32'd5);
        checkOutput("add_b",     opr_b,              32'd7);
        checkOutput("add_rd",    {27'b0, rd},        32'd2);
        checkOutput("add_rd_we", {31'b0, rd_we},     32'd1);

        // srai x3, x1, 4
        applyStimulus(1'b1, 32'h4040D193, 32'h0, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        tick();
        checkOutput("srai_aluop", {28'b0, aluop}, 32'h7);
        checkOutput("srai_a",     opr_a,          32'h80000000);
        checkOutput("srai_b",     opr_b,          32'h00000004);
        checkOutput("srai_rd",    {27'b0, rd},    32'd3);

        // sra x4, x1, x2 with a wide rs2 value
        applyStimulus(1'b1, 32'h4020D233, 32'h0, 32'h12345678, 32'hFFFFFFE3, 1'b1);
        tick();
        checkOutput("sra_aluop", {28'b0, aluop}, 32'h7);
        checkOutput("sra_b",     opr_b,          32'h00000003);
        checkOutput("sra_rd",    {27'b0, rd},    32'd4);

        // jal -- not an ALU opcode
        applyStimulus(1'b1, 32'h0000006F, 32'h40, 32'h1234, 32'h5678, 1'b1);
        tick();
        checkOutput("jal_valid",   {31'b0, out_valid}, 32'd1);
        checkOutput("jal_illegal", {31'b0, illegal},   32'd1);
        checkOutput("jal_rd_we",   {31'b0, rd_we},     32'd0);
        checkOutput("jal_aluop",   {28'b0, aluop},     32'h0);
        checkOutput("jal_a",       opr_a,              32'd0);
        checkOutput("jal_b",       opr_b,              32'd0);

        // lui x5, 0x12345
        applyStimulus(1'b1, 32'h123452B7, 32'h0, 32'hAAAA, 32'h0, 1'b1);
        tick();
        checkOutput("lui_aluop", {28'b0, aluop},  32'hA);
        checkOutput("lui_a",     opr_a,           32'd0);
        checkOutput("lui_b",     opr_b,           32'h12345000);
        checkOutput("lui_rd_we", {31'b0, rd_we},  32'd1);

        // auipc x5, 0x12345 at pc 0x1000
        applyStimulus(1'b1, 32'h12345297, 32'h1000, 32'hAAAA, 32'h0, 1'b1);
        tick();
        checkOutput("auipc_aluop", {28'b0, aluop}, 32'h0);
        checkOutput("auipc_a",     opr_a,          32'h1000);
        checkOutput("auipc_b",     opr_b,          32'h12345000);

        // addi x6, x1, -1
        applyStimulus(1'b1, 32'hFFF08313, 32'h0, 32'd10, 32'h0, 1'b1);
        tick();
        checkOutput("addi_a",  opr_a,       32'd10);
        checkOutput("addi_b",  opr_b,       32'hFFFFFFFF);
        checkOutput("addi_rd", {27'b0, rd}, 32'd6);

        // lw x7, 8(x1)
        applyStimulus(1'b1, 32'h0080A383, 32'h0, 32'h200, 32'h0, 1'b1);
        tick();
        checkOutput("lw_a",     opr_a,          32'h200);
        checkOutput("lw_b",     opr_b,          32'd8);
        checkOutput("lw_rd_we", {31'b0, rd_we}, 32'd1);

        // sw x2, -4(x1)
        applyStimulus(1'b1, 32'hFE20AE23, 32'h0, 32'h100, 32'h55, 1'b1);
        tick();
        checkOutput("sw_aluop",   {28'b0, aluop},   32'h0);
        checkOutput("sw_a",       opr_a,            32'h100);
        checkOutput("sw_b",       opr_b,            32'hFFFFFFFC);
        checkOutput("sw_rd_we",   {31'b0, rd_we},   32'd0);
        checkOutput("sw_illegal", {31'b0, illegal}, 32'd0);

        // funct7 0100000 with funct3 111 is not a valid OP
        applyStimulus(1'b1, 32'h4020F1B3, 32'h0, 32'd9, 32'd9, 1'b1);
        tick();
        checkOutput("badf7_illegal", {31'b0, illegal}, 32'd1);
        checkOutput("badf7_b",       opr_b,            32'd0);

        // add x0, x1, x2 never writes back
        applyStimulus(1'b1, 32'h00208033, 32'h0, 32'd1, 32'd2, 1'b1);
        tick();
        checkOutput("x0_rd_we",   {31'b0, rd_we},   32'd0);
        checkOutput("x0_illegal", {31'b0, illegal}, 32'd0);

        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        checkOutput("drain_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("drain_ready", {31'b0, in_ready},  32'd1);

        // ---- skid buffer: three offers while stalled ----
        applyStimulus(1'b1, addiInstr(5'd1, 12'h011), 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("skA_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("skA_ready", {31'b0, in_ready},  32'd1);
        applyStimulus(1'b1, addiInstr(5'd2, 12'h022), 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("skB_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("skB_rd",    {27'b0, rd},       32'd1);
        checkOutput("skB_b",     opr_b,             32'h011);
        applyStimulus(1'b1, addiInstr(5'd3, 12'h033), 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("skC_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("skC_rd",    {27'b0, rd},       32'd1);
        out_ready = 1'b1;
        tick();
        checkOutput("pop1_rd",    {27'b0, rd},       32'd2);
        checkOutput("pop1_b",     opr_b,             32'h022);
        checkOutput("pop1_ready", {31'b0, in_ready}, 32'd1);
        tick();
        checkOutput("pop2_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("pop2_rd",    {27'b0, rd},        32'd3);
        checkOutput("pop2_b",     opr_b,              32'h033);
        in_valid = 1'b0;
        tick();
        checkOutput("pop3_valid", {31'b0, out_valid}, 32'd0);

        // ---- flush while FULL with an offered entry ----
        applyStimulus(1'b1, addiInstr(5'd1, 12'h011), 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b1, addiInstr(5'd2, 12'h022), 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("flF_full", {31'b0, in_ready}, 32'd0);
        applyStimulus(1'b1, addiInstr(5'd9, 12'h099), 32'h0, 32'h0, 32'h0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flF_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flF_ready", {31'b0, in_ready},  32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        checkOutput("flF_after", {31'b0, out_valid}, 32'd0);

        // ---- flush in ONE drops the entry offered in the same cycle ----
        applyStimulus(1'b1, addiInstr(5'd5, 12'h055), 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b1, addiInstr(5'd6, 12'h066), 32'h0, 32'h0, 32'h0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("fl1_valid", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b0;
        tick();
        checkOutput("fl1_after", {31'b0, out_valid}, 32'd0);

        // ---- asynchronous reset while FULL ----
        applyStimulus(1'b1, addiInstr(5'd1, 12'h011), 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b1, addiInstr(5'd2, 12'h022), 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("arst_ready", {31'b0, in_ready},  32'd1);
        checkOutput("arst_rd",    {27'b0, rd},        32'd0);
        checkOutput("arst_b",     opr_b,              32'd0);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, addiInstr(5'd4, 12'h044), 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("arst_acc_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("arst_acc_rd",    {27'b0, rd},        32'd4);
        checkOutput("arst_acc_b",     opr_b,              32'h044);

        // ---- counters: illegal entry held three cycles, then popped ----
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h0000006F, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("perf_illegal", {31'b0, illegal}, 32'd1);
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        checkOutput("perf_popped", {31'b0, out_valid}, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
        checkOutput("perf_issued", perf_issued, 32'd1);
        checkOutput("perf_stall",  perf_stall,  32'd3);
`else
        checkOutput("perf_issued", perf_issued, 32'd0);
        checkOutput("perf_stall",  perf_stall,  32'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 flush  input  1  synchronous discard of all buffered entries.
REQ-004 in_valid  input  1  upstream entry valid; transfer when in_valid && in_ready.
REQ-005 in_ready  output  1  block can accept an entry.
REQ-006 instr, pc, rs1_data, rs2_data  input  32 each  instruction, its PC, register-file operands.
REQ-007 out_valid  output  1  ALU command valid.
REQ-008 out_ready  input  1  ALU stage accepts; pop = out_valid && out_ready.
REQ-009 aluop  output  4  ALU operation code.
REQ-010 opr_a, opr_b  output  32 each  ALU operands.
REQ-011 rd  output  5  destination register.
REQ-012 rd_we  output  1  writeback enable.
REQ-013 illegal  output  1  decode fault flag.
REQ-014 perf_issued, perf_stall  output  32 each  performance counters.

Function
REQ-015 aluop encoding: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASSB 1010; 1011-1111 never emitted.
REQ-016 OP (0110011): opr_a=rs1_data, opr_b=rs2_data; RV32I funct3 mapping; funct7 0100000 legal only with funct3 000 (SUB) and 101 (SRA); any funct7 other than 0000000/0100000 -> illegal.
REQ-017 OP-IMM (0010011): opr_a=rs1_data, opr_b=sign-extended instr[31:20]; funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
REQ-018 Shifts (funct3 001/101, OP and OP-IMM): opr_b={27'b0, shamt}; shamt=rs2_data[4:0] (OP) or instr[24:20] (OP-IMM); OP-IMM instr[31:25] not 0000000 (or 0100000 for 101) -> illegal.
REQ-019 LUI (0110111): PASSB, opr_a=0, opr_b={instr[31:12],12'b0}; AUIPC (0010111): ADD, opr_a=pc, same opr_b.
REQ-020 LOAD (0000011): ADD, rs1_data + sign-extended I-imm; STORE (0100011): ADD, rs1_data + sign-extended {instr[31:25],instr[11:7]}.
REQ-021 Other opcode or illegal funct: illegal=1, aluop=ADD, opr_a=opr_b=0, rd_we=0; entry still passes through handshake.
REQ-022 rd=instr[11:7]; rd_we=1 only for legal OP/OP-IMM/LUI/AUIPC/LOAD with rd!=0.
REQ-023 Decode on input side; accepted in cycle N into empty buffer -> out_valid in N+1.
REQ-024 Buffer: main register plus one skid register; states EMPTY, ONE, FULL.
REQ-025 in_ready registered, = (next state != FULL); no combinational path out_ready -> in_ready.
REQ-026 Transitions: EMPTY+accept->ONE; ONE+accept, no pop->FULL (skid); ONE+pop, no accept->EMPTY; ONE+accept+pop->ONE; FULL+pop->ONE (skid to main); FULL never accepts.
REQ-027 Output payload stable while out_valid && !out_ready; strict in-order issue.
REQ-028 flush: next state EMPTY, out_valid=0, in_ready=1; entry offered in flush cycle dropped; flush overrides pop and accept.

Reset
REQ-029 rst_n low: state EMPTY, out_valid=0, in_ready=1; aluop, opr_a, opr_b, rd, rd_we, illegal, counters = 0.
REQ-030 Reset mid-operation discards all entries, no partial output; accept possible on first edge after deassertion.

Configuration
REQ-031 ALU_ISSUE_PERF_EN defined: perf_issued +1 per pop; perf_stall +1 per cycle out_valid && !out_ready; both wrap at 2^32; flush does not clear.
REQ-032 ALU_ISSUE_PERF_EN undefined: perf_issued=perf_stall=0 constant, no counter flops.

Verification
REQ-033 instr 0x00208133, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, aluop 0000, opr_a 5, opr_b 7, rd 2, rd_we 1.
REQ-034 instr 0x4040D193 (srai x3,x1,4), rs1=0x80000000 -> aluop 0111, opr_b 0x00000004, rd 3; SRA reg with rs2=0xFFFFFFE3 -> opr_b 0x00000003.
REQ-035 out_ready=0, three back-to-back inputs -> two accepted, in_ready=0 after second, third held; out_ready=1 -> issue in order, third accepted after first pop.
REQ-036 FULL + flush with in_valid=1 -> next cycle out_valid 0, in_ready 1, offered entry never appears.
REQ-037 instr 0x0000006F -> illegal 1, rd_we 0, opr_a=opr_b=0; with ALU_ISSUE_PERF_EN, perf_issued=1 after pop, perf_stall counts held cycles.
